// File: rtl/stream_to_bus_writer_if.sv
// Bus register port plus outgoing sample stream of the audio transmit bridge.
// The slave modport is the bridge itself; master is the CPU/codec side.
interface stream_to_bus_writer_if #(
    parameter int DATA_SIZE = 28
);
    logic                 chipselect;
    logic [1:0]           address;
    logic                 write;
    logic [31:0]          write_data;
    logic                 read;
    logic [31:0]          read_data;
    logic                 sink_valid;
    logic [DATA_SIZE-1:0] sink_data;
    logic                 sink_ready;
    logic                 irq;

    modport slave (
        input  chipselect, address, write, write_data, read, sink_ready,
        output read_data, sink_valid, sink_data, irq
    );

    modport master (
        output chipselect, address, write, write_data, read, sink_ready,
        input  read_data, sink_valid, sink_data, irq
    );
endinterface

// File: rtl/stream_to_bus_writer.sv
// Audio transmit bridge: CPU bus writes fill a sample FIFO that drains onto a
// valid/ready stream, with status/control registers and a low-level interrupt.
module stream_to_bus_writer #(
    parameter int DATA_SIZE  = 28,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    stream_to_bus_writer_if.slave  bus
);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] WMARK_RESET = CNT_W'(DEPTH / 4);
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_WMARK  = 2'd3;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      wmark_q, wmark_d;
    logic [31:0]           read_data_q, read_data_d;
    logic                  sink_valid_q, sink_valid_d;
    logic [DATA_SIZE-1:0]  sink_data_q, sink_data_d;
    logic                  irq_q, irq_d;
    logic                  enable_q, enable_d;
    logic                  irq_en_q, irq_en_d;
    logic                  underrun_q, underrun_d;
    logic                  overflow_q, overflow_d;

    logic        bus_wr;
    logic        wr_data, wr_status, wr_ctrl, wr_wmark;
    logic        empty, full;
    logic        push, drop, load, pop, accept, flush;
    logic [31:0] status_word, ctrl_word, wmark_word;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^bus.write_data[31:DATA_SIZE];

    always_comb begin
        bus_wr    = bus.chipselect && bus.write;
        wr_data   = bus_wr && (bus.address == ADDR_DATA);
        wr_status = bus_wr && (bus.address == ADDR_STATUS);
        wr_ctrl   = bus_wr && (bus.address == ADDR_CTRL);
        wr_wmark  = bus_wr && (bus.address == ADDR_WMARK);

        empty  = (cnt_q == '0);
        full   = (cnt_q == FULL_COUNT);
        push   = wr_data && !full;
        drop   = wr_data && full;
        accept = sink_valid_q && bus.sink_ready;
        // The output register refills whenever it is free or being consumed.
        load   = enable_q && !empty && (!sink_valid_q || bus.sink_ready);
        flush  = wr_ctrl && bus.write_data[2];
        pop    = load && !flush;
    end

    always_comb begin
        status_word                 = '0;
        status_word[ADDR_WIDTH:0]   = cnt_q;
        status_word[16]             = empty;
        status_word[17]             = full;
        status_word[18]             = underrun_q;
        status_word[19]             = overflow_q;
        status_word[20]             = sink_valid_q;

        ctrl_word                   = '0;
        ctrl_word[0]                = enable_q;
        ctrl_word[1]                = irq_en_q;

        wmark_word                  = '0;
        wmark_word[ADDR_WIDTH:0]    = wmark_q;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        wmark_d      = wmark_q;
        read_data_d  = read_data_q;
        sink_valid_d = sink_valid_q;
        sink_data_d  = sink_data_q;
        enable_d     = enable_q;
        irq_en_d     = irq_en_q;
        underrun_d   = underrun_q;
        overflow_d   = overflow_q;

        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            cnt_d        = '0;
            sink_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                sink_valid_d = 1'b1;
                sink_data_d  = mem[rd_ptr_q];
            end else if (accept) begin
                sink_valid_d = 1'b0;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        // Clear first so that a same-cycle set event wins over the W1C.
        if (wr_status && bus.write_data[18]) underrun_d = 1'b0;
        if (wr_status && bus.write_data[19]) overflow_d = 1'b0;
        if (accept && enable_q && empty)     underrun_d = 1'b1;
        if (drop)                            overflow_d = 1'b1;

        if (wr_ctrl) begin
            enable_d = bus.write_data[0];
            irq_en_d = bus.write_data[1];
        end
        if (wr_wmark) begin
            wmark_d = bus.write_data[ADDR_WIDTH:0];
        end

        irq_d = irq_en_q && ((cnt_q <= wmark_q) || underrun_q);

        if (bus.chipselect && bus.read) begin
            case (bus.address)
                ADDR_STATUS: read_data_d = status_word;
                ADDR_CTRL:   read_data_d = ctrl_word;
                ADDR_WMARK:  read_data_d = wmark_word;
                default:     read_data_d = '0;
            endcase
        end
    end

    // Sample storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.write_data[DATA_SIZE-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            wmark_q      <= WMARK_RESET;
            read_data_q  <= '0;
            sink_valid_q <= 1'b0;
            sink_data_q  <= '0;
            irq_q        <= 1'b0;
            enable_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            wmark_q      <= wmark_d;
            read_data_q  <= read_data_d;
            sink_valid_q <= sink_valid_d;
            sink_data_q  <= sink_data_d;
            irq_q        <= irq_d;
            enable_q     <= enable_d;
            irq_en_q     <= irq_en_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.read_data  = read_data_q;
    assign bus.sink_valid = sink_valid_q;
    assign bus.sink_data  = sink_data_q;
    assign bus.irq        = irq_q;

endmodule

// File: doc/stream_to_bus_writer.md
Name: stream_to_bus_writer

Overview:
- Bus-to-stream bridge for the audio output path; the transmit-side counterpart of the capture bridge.
- CPU pushes samples with bus writes into an internal DEPTH × DATA_SIZE FIFO.
- The block drains the FIFO onto a valid/ready stream toward the DAC/codec serializer.
- Provides status, control and a level-watermark interrupt so the driver can refill before the FIFO runs dry.

Parameters:
- DATA_SIZE, 28, stream sample width (bits); bus write data truncated to the low DATA_SIZE bits.
- DEPTH, 2048, FIFO entries; power of two.
- ADDR_WIDTH, $clog2(DEPTH), FIFO pointer width.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, asynchronous, active-high.
- chipselect  in  1  bus select.
- address  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 WMARK.
- write  in  1  bus write strobe.
- write_data  in  32  bus write data.
- read  in  1  bus read strobe.
- read_data  out  32  registered read data.
- sink_valid  out  1  stream output data valid.
- sink_data  out  DATA_SIZE  stream sample.
- sink_ready  in  1  downstream accepts when high with sink_valid.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset (async assert, sync release): pointers, cnt, read_data, sink_valid, sink_data, irq, enable, irq_en, underrun and overflow all clear; wmark = DEPTH/4 (512).
- Register map:
  - DATA (addr 0), write-only: push write_data[DATA_SIZE-1:0]. Reads return 0.
  - STATUS (addr 1): [ADDR_WIDTH:0] cnt, [16] empty, [17] full, [18] underrun, [19] overflow, [20] sink_valid; other bits 0.
  - STATUS write: W1C on bits 18 and 19; other bits ignored.
  - CTRL (addr 2): [0] enable, [1] irq_en, [2] flush. Flush is self-clearing and always reads 0.
  - WMARK (addr 3): [ADDR_WIDTH:0] low watermark, read/write.
- Read timing: read_data is updated on the clock edge where chipselect && read; latency 1 cycle. Otherwise read_data holds its value. Reads have no side effects.
- Push:
  - Occurs when chipselect && write && address==0 && !full.
  - Write while full: data dropped, overflow sets (sticky).
- Output register (sink_valid/sink_data):
  - Loads when enable && !empty && (!sink_valid || sink_ready). It pops mem[rd_ptr], sink_valid=1 next cycle, and rd_ptr increments, wrapping DEPTH-1→0.
  - When sink_valid && sink_ready and no load occurs, sink_valid clears.
  - sink_valid and sink_data must be held stable while !sink_ready.
  - Throughput: 1 sample/cycle while ready is held high and the FIFO is non-empty.
- cnt counts FIFO entries only (excludes the output register), range 0..DEPTH.
  - push only: +1; pop only: −1; push and pop in the same cycle: unchanged.
  - full = cnt==DEPTH; empty = cnt==0.
- Push into an empty FIFO: the earliest possible load is the following cycle (no write-through).
- Enable cleared mid-stream: a pending sink_valid is not retracted and stays until accepted. No further loads occur; FIFO contents are preserved.
- Underrun (sticky): sets on the cycle sink_valid && sink_ready && enable && empty, i.e. the stream goes dry after starting. Enabling with an empty FIFO does not set it.
- Flush (CTRL write with bit2=1):
  - In one cycle, clears wr_ptr, rd_ptr, cnt and sink_valid.
  - The enable and irq_en bits from the same write still take effect.
  - Flush has priority over a simultaneous pop.
- W1C and a same-cycle set: the set wins.
- irq is registered: irq <= irq_en && ((cnt <= wmark) || underrun). It deasserts one cycle after the condition clears.
- Reset mid-operation: immediate return to reset state; in-flight sink_valid drops asynchronously.

Test Plan:
- After reset, read STATUS (addr 1) → read_data = 0x0001_0000 (empty=1, cnt=0); sink_valid=0; irq=0.
- With enable=0, write 3 samples 0x0000001, 0x0ABCDEF, 0xFFFFFFF to DATA → STATUS cnt=3, sink_valid=0. Then write CTRL=1 with sink_ready=1 → sink_data sequence 0x0000001, 0x0ABCDEF, 0xFFFFFFF on consecutive cycles. Underrun sets on the 3rd accept; cnt=0.
- Backpressure: 4 samples queued, enable=1, sink_ready=0 for 10 cycles → sink_valid=1 with the first sample held constant, cnt=3. Releasing ready drains in order.
- Fill: 2048 writes then 1 extra (0x1234567) with enable=0 → full=1, cnt=2048, overflow=1, extra dropped. Draining yields exactly the 2048 written values, wrapping rd_ptr; STATUS W1C 0x000C_0000 clears both flags.
- Watermark irq: wmark=2, irq_en=1, 5 samples queued, draining → irq rises the cycle after cnt reaches 2; writing 3 more samples drops irq one cycle after cnt>2.
- Flush and async reset: 10 queued with sink_valid=1 and sink_ready=0, write CTRL=0x5 → next cycle cnt=0, sink_valid=0, enable=1. Re-queue 2 samples, then pulse rst mid-cycle → all outputs 0 immediately, irq=0.
